// File: rtl/mem_responder.sv
// Word-addressed memory behind the MAR/MDR datapath with a fixed access latency.
// Ports: clk, clr (async active-low), read/write levels, address, data_in -> Mdatain, mem_ready, busy, error.
module mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_ready,
  output logic              busy,
  output logic              error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_HOLD
  } state_t;

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nx;
  logic              r_op_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_latch;
  logic              w_access;
  logic              w_busy_nx;
  logic              w_ready_nx;
  logic              w_err_nx;
  logic              w_in_range;
  logic [31:0]       w_addr_ext;
  logic [IW-1:0]     w_idx;

  logic [DATA_W-1:0] mem [DEPTH];

  // Widen before comparing so DEPTH == 2**ADDR_W does not make
  // the range check a constant on a narrow operand.
  assign w_addr_ext = 32'(r_addr);
  assign w_in_range = (w_addr_ext < 32'(DEPTH));
  assign w_idx      = r_addr[IW-1:0];

  always_comb begin
    w_next     = r_state;
    w_cnt_nx   = r_cnt;
    w_latch    = 1'b0;
    w_access   = 1'b0;
    w_busy_nx  = 1'b0;
    w_ready_nx = 1'b0;
    w_err_nx   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (read && write) begin
          w_err_nx = 1'b1;
          w_next   = S_HOLD;
        end else if (read || write) begin
          w_latch   = 1'b1;
          w_cnt_nx  = CW'(LATENCY - 1);
          w_busy_nx = 1'b1;
          w_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        w_busy_nx = 1'b1;
        if (r_cnt == '0) begin
          w_access   = 1'b1;
          w_ready_nx = 1'b1;
          w_err_nx   = !w_in_range;
          w_next     = S_DONE;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      S_DONE: begin
        w_next = (read || write) ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!read && !write) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op_wr   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      Mdatain   <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_nx;
      mem_ready <= w_ready_nx;
      busy      <= w_busy_nx;
      error     <= w_err_nx;
      if (w_latch) begin
        r_op_wr <= write;
        r_addr  <= address;
        r_data  <= data_in;
      end
      if (w_access && !r_op_wr && w_in_range)
        Mdatain <= mem[w_idx];
    end
  end

  // Storage is not reset; a reset mid-access drops the state to
  // IDLE, so w_access never fires for the abandoned request.
  always_ff @(posedge clk) begin
    if (w_access && r_op_wr && w_in_range)
      mem[w_idx] <= r_data;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default build (LATENCY=2, DEPTH=512)
// plus a DEPTH=256, LATENCY=1 build for range and minimum-latency cases.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clr;
  logic        rd0, wr0, rd1, wr1;
  logic [8:0]  a0, a1;
  logic [31:0] d0, d1;
  logic [31:0] q0, q1;
  logic        mr0, bz0, er0;
  logic        mr1, bz1, er1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_responder u_dut0 (
    .clk(clk), .clr(clr), .read(rd0), .write(wr0),
    .address(a0), .data_in(d0), .Mdatain(q0),
    .mem_ready(mr0), .busy(bz0), .error(er0)
  );

  mem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .clr(clr), .read(rd1), .write(wr1),
    .address(a1), .data_in(d1), .Mdatain(q1),
    .mem_ready(mr1), .busy(bz1), .error(er1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic f_mr(input int d);
    return (d == 0) ? mr0 : mr1;
  endfunction

  task automatic drive(input int d, input logic r, input logic w,
                       input logic [8:0] a, input logic [31:0] dat);
    if (d == 0) begin
      rd0 = r; wr0 = w; a0 = a; d0 = dat;
    end else begin
      rd1 = r; wr1 = w; a1 = a; d1 = dat;
    end
  endtask

  // Issue one request; lat = edges from sampling edge to mem_ready.
  task automatic req(input int d, input logic r, input logic w,
                     input logic [8:0] a, input logic [31:0] dat,
                     output int lat, output logic [31:0] q,
                     output logic e);
    @(negedge clk);
    drive(d, r, w, a, dat);
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!f_mr(d) && lat < 20);
    q = (d == 0) ? q0 : q1;
    e = (d == 0) ? er0 : er1;
    @(negedge clk);
    drive(d, 1'b0, 1'b0, a, dat);
  endtask

  initial begin
    int          lat;
    logic [31:0] q;
    logic        e;
    int          pulses;
    int          bad;

    clr = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    check("rst_q", q0, 32'h0);
    check("rst_busy", 32'(bz0), 32'h0);
    clr = 1'b1;

    req(0, 1'b0, 1'b1, 9'd5, 32'h11111111, lat, q, e);
    check("wr5_lat", lat, 2);
    req(0, 1'b1, 1'b0, 9'd5, 32'h0, lat, q, e);
    check("rd5_lat", lat, 2);
    check("rd5_q", q, 32'h11111111);
    check("rd5_err", 32'(e), 32'h0);

    // Reset mid-WAIT of a write.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 9'd5, 32'hDEADBEEF);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("wait_busy", 32'(bz0), 32'h1);
    clr = 1'b0;
    #1;
    check("arst_q", q0, 32'h0);
    check("arst_busy", 32'(bz0), 32'h0);
    check("arst_rdy", 32'(mr0), 32'h0);
    check("arst_err", 32'(er0), 32'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 9'd5, 32'h0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (mr0) pulses++;
    end
    check("arst_noready", pulses, 0);
    req(0, 1'b1, 1'b0, 9'd5, 32'h0, lat, q, e);
    check("arst_rd5", q, 32'h11111111);

    // Write then read.
    req(0, 1'b0, 1'b1, 9'h0A, 32'h12345678, lat, q, e);
    check("wrA_lat", lat, 2);
    req(0, 1'b1, 1'b0, 9'h0A, 32'h0, lat, q, e);
    check("rdA_lat", lat, 2);
    check("rdA_q", q, 32'h12345678);

    // Held read: one access, busy low in HOLD.
    req(0, 1'b0, 1'b1, 9'd3, 32'h33333333, lat, q, e);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 9'd3, 32'h0);
    pulses = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (mr0) pulses++;
      if (i >= 3 && bz0) bad++;
    end
    check("hold_pulses", pulses, 1);
    check("hold_busy", bad, 0);
    check("hold_q", q0, 32'h33333333);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 9'd3, 32'h0);

    // Address/data change during WAIT is ignored.
    req(0, 1'b0, 1'b1, 9'd7, 32'h77777777, lat, q, e);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 9'd4, 32'hA5A5A5A5);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 9'd7, 32'hFFFFFFFF);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!mr0 && lat < 20);
    check("chg_lat", lat, 2);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 9'd0, 32'h0);
    req(0, 1'b1, 1'b0, 9'd4, 32'h0, lat, q, e);
    check("chg_rd4", q, 32'hA5A5A5A5);
    req(0, 1'b1, 1'b0, 9'd7, 32'h0, lat, q, e);
    check("chg_rd7", q, 32'h77777777);

    // Simultaneous read and write.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 9'h0A, 32'h0BAD0BAD);
    @(posedge clk);
    #1;
    check("rw_err", 32'(er0), 32'h1);
    check("rw_busy", 32'(bz0), 32'h0);
    @(posedge clk);
    #1;
    check("rw_err_end", 32'(er0), 32'h0);
    pulses = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (mr0) pulses++;
    end
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 9'h0A, 32'h0BAD0BAD);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (mr0) pulses++;
    end
    check("rw_noready", pulses, 0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 9'h0A, 32'h0);
    req(0, 1'b1, 1'b0, 9'h0A, 32'h0, lat, q, e);
    check("rw_next_lat", lat, 2);
    check("rw_next_q", q, 32'h12345678);

    // DEPTH=256, LATENCY=1 build.
    req(1, 1'b0, 1'b1, 9'h010, 32'hCAFEF00D, lat, q, e);
    check("l1_wr_lat", lat, 1);
    req(1, 1'b1, 1'b0, 9'h010, 32'h0, lat, q, e);
    check("l1_rd_lat", lat, 1);
    check("l1_rd_q", q, 32'hCAFEF00D);
    req(1, 1'b1, 1'b0, 9'h1FF, 32'h0, lat, q, e);
    check("oor_lat", lat, 1);
    check("oor_err", 32'(e), 32'h1);
    check("oor_q", q, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    check("oor_err_end", 32'(er1), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed memory that services the CPU datapath's memory-data-register traffic.
- Read data is driven onto Mdatain, which the MDR captures when read=1.
- Write data is taken from the MDR output q; the address is taken from the MAR output.
- Fixed, parameterised access latency, signalled by a one-cycle mem_ready pulse, so control logic can stall until data is valid.

Parameters:
- DATA_W, 32, word width; must match MDR width.
- ADDR_W, 9, address width in words.
- DEPTH, 512, number of implemented words; must satisfy DEPTH <= 2^ADDR_W.
- LATENCY, 2, number of clock edges from request sample to mem_ready; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- clr  input  1  reset; asynchronous, active-low (clr=0 resets).
- read  input  1  read request level from control unit.
- write  input  1  write request level from control unit.
- address  input  ADDR_W  word address from MAR.
- data_in  input  DATA_W  write data from MDR q.
- Mdatain  output  DATA_W  registered read data to the MDR mux.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high while a request is in flight (WAIT or DONE).
- error  output  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (clr=0, asynchronous, any state):
  - State goes to IDLE; wait counter clears.
  - Mdatain=0, mem_ready=0, busy=0, error=0.
  - Storage array contents are NOT cleared.
  - A request in flight at reset is abandoned: no array write occurs and no mem_ready is issued.
- States: IDLE, WAIT, DONE, HOLD.
- IDLE:
  - read=1 and write=1 on the same edge: error=1 for one cycle, then go to HOLD. No access.
  - Exactly one of read/write high: latch op, address and data_in; counter=LATENCY-1; go to WAIT; busy=1 from the next cycle.
  - Neither high: stay in IDLE.
- WAIT:
  - Counter decrements each edge.
  - At counter==0 the access is performed on that edge and the state goes to DONE.
  - Changes on read, write, address and data_in during WAIT are ignored; latched values are used.
- Access, at the WAIT-to-DONE edge:
  - Write: mem[latched address] <= latched data.
  - Read: Mdatain <= mem[latched address].
  - Latched address >= DEPTH: no array access, Mdatain unchanged, error=1 during DONE.
- DONE (exactly one cycle):
  - mem_ready=1, busy=1.
  - Next state is HOLD if read or write is still high, else IDLE.
- HOLD:
  - busy=0; wait until read=0 and write=0, then go to IDLE.
  - A level held high therefore produces exactly one access.
  - New requests are accepted only from IDLE.
- Timing:
  - mem_ready rises in the cycle following the LATENCY-th edge after the sampling edge.
  - Read data on Mdatain is valid in the same cycle as mem_ready and holds until the next completed read or reset.
- Mdatain, mem_ready, busy and error are all registered outputs; there is no combinational path from inputs to outputs.
- Back-to-back requests: after DONE with the request dropped, the next request is sampled in IDLE, giving a minimum of one idle cycle between accesses.
- Read-after-write to the same address returns the newly written value.
- Write data is taken from the latched data_in, not the live bus.

Test Plan:
- Reset:
  - Stimulus: assert clr=0 mid-WAIT of a write of 32'hDEADBEEF to address 5; release; read address 5.
  - Required: outputs 0 immediately on reset, no mem_ready, and the read returns the prior contents of address 5 (not DEADBEEF).
- Write then read, LATENCY=2:
  - Stimulus: write 32'h12345678 to address 9'h0A; drop the request; read address 9'h0A.
  - Required: each mem_ready occurs 2 edges after its sample; Mdatain=32'h12345678 in the read's mem_ready cycle.
- Held request:
  - Stimulus: read held high for 10 cycles at address 3.
  - Required: exactly one mem_ready pulse; FSM in HOLD until read=0; busy=0 in HOLD.
- Input changes in flight:
  - Stimulus: change address from 4 to 7 and data_in during WAIT of a write to address 4 with 32'hA5A5A5A5.
  - Required: address 4 holds A5A5A5A5; address 7 is unchanged.
- Simultaneous read/write:
  - Stimulus: read=1 and write=1 together.
  - Required: one error pulse, no mem_ready, no array change; the next lone read is serviced after both inputs drop.
- Out-of-range and minimum latency:
  - Stimulus: DEPTH=256 with a read of address 9'h1FF; separately LATENCY=1.
  - Required: out-of-range read gives mem_ready and error together with Mdatain unchanged; with LATENCY=1, mem_ready rises 1 edge after the sample.
